uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmitter: accepts bytes on an AXI-stream-style input, queues them in a small FIFO, and serializes each as an 8N1 frame (start, 8 data bits LSB first, one stop bit) on `txd`. It runs entirely in the `clk_in` domain and shares the 16-bit prescaler definition used by the UART peripheral. It slots in behind the bus register file as the transmit engine, letting software queue several bytes before polling.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `CW`, default `$clog2(FIFO_DEPTH+1)`: width of `fifo_count`.

- `clk_in`  in  1  transmit clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `prescale`  in  16  bit period = 8 × max(prescale, 1) `clk_in` cycles.
- `input_axis_tdata`  in  8  byte to send.
- `input_axis_tvalid`  in  1  producer has data.
- `input_axis_tready`  out  1  FIFO can accept; equals `fifo_count != FIFO_DEPTH`.
- `txd`  out  1  serial output; idle high.
- `busy`  out  1  frame in progress (state ≠ IDLE).
- `fifo_count`  out  CW  entries currently queued (excludes the byte being shifted).

## Operation
- Reset values: `txd`=1, `busy`=0, `fifo_count`=0, `input_axis_tready`=1. FIFO pointers cleared, state IDLE. Reset mid-frame aborts it: `txd` returns high asynchronously, queued bytes are discarded.
- Push: on an edge with `tvalid & tready`, write `tdata` at the write pointer and increment it. `tready` comes only from registered `fifo_count`; no combinational path from `tvalid`.
- Pop: in IDLE with `fifo_count > 0`, the edge pops the head into the shift register, latches `P = 8*max(prescale,1)`, loads the bit counter with `P-1`, drives `txd`=0, and enters START.
- Simultaneous push and pop: count unchanged, both pointers advance. A pop on an edge where the FIFO is full does not make `tready` high on that same edge; it rises on the following cycle.
- Pointers wrap modulo `FIFO_DEPTH`; count saturates by construction (no push when full, no pop when empty).
- FSM states:
  - IDLE: `txd`=1. Transition to START on pop.
  - START: `txd`=0 for P cycles. Then go to DATA with bit index 0 and `txd`=data[0].
  - DATA: each bit is held P cycles, LSB first. After bit 7 expires, go to STOP with `txd`=1.
  - STOP: `txd`=1 for P cycles, then go to IDLE. If the FIFO is non-empty on that expiry edge, pop directly and go to START instead. There is no idle gap between back-to-back frames.
- `prescale` is sampled only at pop. Changes during a frame apply to the next frame.
- `prescale`=0 behaves exactly like 1.
- Bit counter is 19 bits (max P = 524280).

## Timing
- Accept-to-start-bit latency: a byte accepted at edge k into an empty FIFO with IDLE state is popped at edge k+1, and `txd` falls after edge k+1.
- Frame length is exactly 10·P cycles. Back-to-back frame starts are 10·P cycles apart.
- `busy` rises on the pop edge and falls on the STOP-expiry edge when the FIFO is empty.
- `fifo_count` and `tready` update on the push/pop edge.
- All outputs are registered. `tready` is a registered compare.

## Test plan
- prescale=1, single push of 0x55 into an idle block → `txd` falls 1 cycle after accept, then reads 0,1,0,1,0,1,0,1,0,1 with each level held 8 cycles. `busy` is high for exactly 80 cycles, and `txd`=1 afterward.
- prescale=0, push 0xA3 → identical timing to prescale=1. Data bits LSB-first: 1,1,0,0,0,1,0,1.
- FIFO_DEPTH=4, prescale=2, `tvalid` held high with bytes 0x01–0x06 from cycle 0 → five bytes are accepted on consecutive edges (the first is popped at edge 1) and `tready`=0 after the 5th. The 6th byte is accepted one cycle after the first frame ends (edge 161). Frames start 160 cycles apart with no gap, in order 01…06.
- Change `prescale` from 1 to 3 mid-frame of byte 0x0F, with byte 0xF0 queued → 0x0F completes at 8 cycles/bit, then 0xF0 runs at 24 cycles/bit.
- Assert `rst` during DATA bit 4 with 2 bytes queued → `txd`=1, `busy`=0, `fifo_count`=0 immediately. After release, nothing is transmitted until a new push arrives.
- Push on the same edge as a pop with `fifo_count`=2 → count stays 2 and byte order is preserved.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: AXI-stream byte input, small FIFO,
// serializer with a 16-bit prescaler (bit period = 8*max(prescale,1)).
// Ports:
//   clk_in, rst (async, active-high)
//   prescale            bit period select, sampled when a byte is popped
//   input_axis_tdata/tvalid/tready   byte input handshake
//   txd                 serial output, idle high
//   busy                frame in progress
//   fifo_count          bytes queued, not counting the one being shifted
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic [15:0]   prescale,
   input  logic [7:0]    input_axis_tdata,
   input  logic          input_axis_tvalid,
   output logic          input_axis_tready,
   output logic          txd,
   output logic          busy,
   output logic [CW-1:0] fifo_count
);

   localparam int          AW   = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    shreg;
   logic [2:0]    bit_idx;
   logic [18:0]   bit_cnt;
   logic [18:0]   period;
   logic [18:0]   period_new;
   logic [15:0]   ps_eff;
   logic          push;
   logic          pop;
   logic          expire;
   logic [CW-1:0] count_nxt;

   assign ps_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
   assign period_new = {ps_eff, 3'b000};
   assign expire     = (bit_cnt == 19'd0);
   assign push       = input_axis_tvalid & input_axis_tready;

   // A new frame starts from IDLE, or straight out of an expiring
   // stop bit so back-to-back frames have no idle gap.
   assign pop = (fifo_count != '0) &&
                ((state == IDLE) || ((state == STOP) && expire));

   always_comb begin
      count_nxt = fifo_count;
      if (push && !pop)
         count_nxt = fifo_count + 1'b1;
      else if (pop && !push)
         count_nxt = fifo_count - 1'b1;
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_in) begin
      if (push)
         mem[wr_ptr] <= input_axis_tdata;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         txd               <= 1'b1;
         busy              <= 1'b0;
         shreg             <= 8'd0;
         bit_idx           <= 3'd0;
         bit_cnt           <= 19'd0;
         period            <= 19'd0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         fifo_count        <= '0;
         input_axis_tready <= 1'b1;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         fifo_count        <= count_nxt;
         input_axis_tready <= (count_nxt != FULL);

         if (pop) begin
            shreg   <= mem[rd_ptr];
            period  <= period_new;
            bit_cnt <= period_new - 19'd1;
            txd     <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
         end else begin
            unique case (state)
               IDLE: begin
                  txd  <= 1'b1;
                  busy <= 1'b0;
               end
               START: begin
                  if (expire) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                     txd     <= shreg[0];
                     bit_cnt <= period - 19'd1;
                  end else begin
                     bit_cnt <= bit_cnt - 19'd1;
                  end
               end
               DATA: begin
                  if (expire) begin
                     bit_cnt <= period - 19'd1;
                     if (bit_idx == 3'd7) begin
                        state <= STOP;
                        txd   <= 1'b1;
                     end else begin
                        bit_idx <= bit_idx + 3'd1;
                        txd     <= shreg[1];
                        shreg   <= shreg >> 1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt - 19'd1;
                  end
               end
               STOP: begin
                  if (expire) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     txd   <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt - 19'd1;
                  end
               end
               default: begin
                  state <= IDLE;
                  txd   <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
